// File: rtl/ram_access_arbiter_pkg.sv
// Shared definitions for the data-RAM access arbiter.
//   state_t      : arbiter FSM states
//   RW_*         : rw_type encodings used on requester and RAM sides
//   PORT0/PORT1  : requester ids (0 = core LSU, 1 = debug/boot loader)
//   misaligned() : true when an access type/address pair must be rejected
package ram_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_MERGE,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [2:0] RW_LB  = 3'b000;
  localparam logic [2:0] RW_LH  = 3'b001;
  localparam logic [2:0] RW_LW  = 3'b010;
  localparam logic [2:0] RW_LBU = 3'b100;
  localparam logic [2:0] RW_LHU = 3'b101;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Halfwords need an even address, words a 4-byte aligned one; the unused
  // type codes 011/110/111 are rejected the same way.
  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    case (t)
      RW_LB, RW_LBU: misaligned = 1'b0;
      RW_LH, RW_LHU: misaligned = a[0];
      RW_LW:         misaligned = (a != 2'b00);
      default:       misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Bundle of requester and RAM-side signals of the data-RAM arbiter.
//   pN_req/we/type/addr/wdata : request from port N (held until pN_ack)
//   pN_ack/err/rdata          : completion pulse, misalignment flag, load data
//   ram_wr_en/addr/rw_type/dat_i : RAM command, ram_dat_o : RAM read data
//   busy                      : arbiter is not idle
// Modports: slave = arbiter side, master = requester/RAM side.
interface ram_arb_if #(
  parameter int ADDR_W = 32
);
  logic              p0_req, p1_req;
  logic              p0_we, p1_we;
  logic [2:0]        p0_type, p1_type;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [31:0]       p0_wdata, p1_wdata;
  logic              p0_ack, p1_ack;
  logic              p0_err, p1_err;
  logic [31:0]       p0_rdata, p1_rdata;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [2:0]        ram_rw_type;
  logic [31:0]       ram_dat_i;
  logic [31:0]       ram_dat_o;
  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_type, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_type, p1_addr, p1_wdata,
    output p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata,
    output ram_wr_en, ram_addr, ram_rw_type, ram_dat_i,
    input  ram_dat_o,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_type, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_type, p1_addr, p1_wdata,
    input  p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata,
    input  ram_wr_en, ram_addr, ram_rw_type, ram_dat_i,
    output ram_dat_o,
    input  busy
  );
endinterface

// File: rtl/ram_access_arbiter_rr_pick.sv
// Two-way round-robin picker.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : pending requests (bit N = port N)
//   take     : the current pick is granted this cycle; remember it
//   pick     : winning port id (only meaningful when a req is set)
// The last-grant register resets to PORT1 so port 0 wins the first tie.
module ram_rr_pick
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       pick
);

  logic last_q;

  always_comb begin
    pick = PORT0;
    if (req[1] && !req[0]) pick = PORT1;
    else if (req[1] && req[0]) pick = ~last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= PORT1;
    else if (take) last_q <= pick;
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Arbiter sharing the single-port data RAM between the core load/store unit
// (port 0) and the debug/boot loader (port 1). Sub-word stores get a read
// cycle before the write so the RAM can merge into the old word; misaligned
// accesses are answered with err and never reach the RAM.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ram_arb_if.slave (requester ports, RAM command/data, busy)
// Parameters: RD_LAT (1 or 2 RAM read latency), ADDR_W (address width).
// Build option: RAM_ARB_FIXED_PRIO_EN - port 0 always wins ties and the
// round-robin picker is left out.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst,
  ram_arb_if.slave  bus
);

  state_t            state;
  logic              port_q, we_q, merge_q;
  logic [1:0]        cnt_q;
  logic              ack0_q, ack1_q, err0_q, err1_q;
  logic [31:0]       rdata0_q, rdata1_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [2:0]        ram_type_q;
  logic [31:0]       ram_dat_q;

  logic              any_req, pick;
  logic              sel_we;
  logic [2:0]        sel_type;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  assign any_req = bus.p0_req | bus.p1_req;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign pick = bus.p0_req ? PORT0 : PORT1;
`else
  logic take;
  assign take = (state == S_IDLE) && any_req;

  ram_rr_pick u_pick (
    .clk  (clk),
    .rst  (rst),
    .req  ({bus.p1_req, bus.p0_req}),
    .take (take),
    .pick (pick)
  );
`endif

  assign sel_we    = pick ? bus.p1_we    : bus.p0_we;
  assign sel_type  = pick ? bus.p1_type  : bus.p0_type;
  assign sel_addr  = pick ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = pick ? bus.p1_wdata : bus.p0_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      port_q     <= PORT0;
      we_q       <= 1'b0;
      merge_q    <= 1'b0;
      cnt_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      wr_en_q    <= 1'b0;
      ram_addr_q <= '0;
      ram_type_q <= RW_LW;
    end else begin
      unique case (state)
        // Grant: the RAM command registers are the latched request fields.
        S_IDLE: begin
          if (any_req) begin
            port_q <= pick;
            we_q   <= sel_we;
            if (misaligned(sel_type, sel_addr[1:0])) begin
              ack0_q <= (pick == PORT0);
              ack1_q <= (pick == PORT1);
              err0_q <= (pick == PORT0);
              err1_q <= (pick == PORT1);
              state  <= S_DONE;
            end else begin
              ram_addr_q <= sel_addr;
              ram_type_q <= sel_type;
              ram_dat_q  <= sel_wdata;
              wr_en_q    <= sel_we && (sel_type == RW_LW);
              state      <= S_ACCESS;
            end
          end
        end
        // Address presented; a word store is written here.
        S_ACCESS: begin
          if (we_q && ram_type_q == RW_LW) begin
            wr_en_q <= 1'b0;
            ack0_q  <= (port_q == PORT0);
            ack1_q  <= (port_q == PORT1);
            state   <= S_DONE;
          end else if (we_q) begin
            // Old word is on ram_dat_o RD_LAT cycles after this edge; the
            // merge write must overlap that cycle.
            merge_q <= 1'b1;
            if (RD_LAT == 1) begin
              wr_en_q <= 1'b1;
              state   <= S_MERGE;
            end else begin
              cnt_q <= 2'(RD_LAT - 2);
              state <= S_CAPTURE;
            end
          end else begin
            merge_q <= 1'b0;
            cnt_q   <= 2'(RD_LAT - 1);
            state   <= S_CAPTURE;
          end
        end
        // Read-latency wait; loads register RAM data on the last cycle.
        S_CAPTURE: begin
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else if (merge_q) begin
            wr_en_q <= 1'b1;
            state   <= S_MERGE;
          end else begin
            if (port_q == PORT0) rdata0_q <= bus.ram_dat_o;
            else                 rdata1_q <= bus.ram_dat_o;
            ack0_q <= (port_q == PORT0);
            ack1_q <= (port_q == PORT1);
            state  <= S_DONE;
          end
        end
        // Sub-word write into the old word at the same address.
        S_MERGE: begin
          wr_en_q <= 1'b0;
          ack0_q  <= (port_q == PORT0);
          ack1_q  <= (port_q == PORT1);
          state   <= S_DONE;
        end
        // One-cycle ack; IDLE re-samples requests on the following cycle.
        S_DONE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          err0_q <= 1'b0;
          err1_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A write in flight when reset hits is dropped in that very cycle.
  assign bus.ram_wr_en   = wr_en_q & ~rst;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_rw_type = ram_type_q;
  assign bus.ram_dat_i   = ram_dat_q;
  assign bus.p0_ack      = ack0_q;
  assign bus.p1_ack      = ack1_q;
  assign bus.p0_err      = err0_q;
  assign bus.p1_err      = err1_q;
  assign bus.p0_rdata    = rdata0_q;
  assign bus.p1_rdata    = rdata1_q;
  assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: dut1 uses RD_LAT=1, dut2 RD_LAT=2,
// each with its own behavioural sync-read RAM. dsel routes the shared
// requester stimulus to one DUT and selects which DUT's outputs are observed.
// Latency is counted in clock edges from the request up to the edge on which
// the requester samples ack.
module tb_ram_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   dsel = 1'b0;

  always #5 clk = ~clk;

  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [2:0]  p0_type = 3'b010, p1_type = 3'b010;
  logic [31:0] p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;

  ram_arb_if #(.ADDR_W(32)) bus1 ();
  ram_arb_if #(.ADDR_W(32)) bus2 ();

  ram_access_arbiter #(.RD_LAT(1), .ADDR_W(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ram_access_arbiter #(.RD_LAT(2), .ADDR_W(32)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus1.p0_req = p0_req & ~dsel;
  assign bus2.p0_req = p0_req & dsel;
  assign bus1.p1_req = p1_req & ~dsel;
  assign bus2.p1_req = p1_req & dsel;
  assign bus1.p0_we = p0_we;       assign bus2.p0_we = p0_we;
  assign bus1.p1_we = p1_we;       assign bus2.p1_we = p1_we;
  assign bus1.p0_type = p0_type;   assign bus2.p0_type = p0_type;
  assign bus1.p1_type = p1_type;   assign bus2.p1_type = p1_type;
  assign bus1.p0_addr = p0_addr;   assign bus2.p0_addr = p0_addr;
  assign bus1.p1_addr = p1_addr;   assign bus2.p1_addr = p1_addr;
  assign bus1.p0_wdata = p0_wdata; assign bus2.p0_wdata = p0_wdata;
  assign bus1.p1_wdata = p1_wdata; assign bus2.p1_wdata = p1_wdata;

  logic        ack0, ack1, err0, err1, wr_en, busy;
  logic [31:0] rdata0, rdata1, ram_addr;
  logic [2:0]  rw_type;
  assign ack0     = dsel ? bus2.p0_ack      : bus1.p0_ack;
  assign ack1     = dsel ? bus2.p1_ack      : bus1.p1_ack;
  assign err0     = dsel ? bus2.p0_err      : bus1.p0_err;
  assign err1     = dsel ? bus2.p1_err      : bus1.p1_err;
  assign rdata0   = dsel ? bus2.p0_rdata    : bus1.p0_rdata;
  assign rdata1   = dsel ? bus2.p1_rdata    : bus1.p1_rdata;
  assign wr_en    = dsel ? bus2.ram_wr_en   : bus1.ram_wr_en;
  assign ram_addr = dsel ? bus2.ram_addr    : bus1.ram_addr;
  assign rw_type  = dsel ? bus2.ram_rw_type : bus1.ram_rw_type;
  assign busy     = dsel ? bus2.busy        : bus1.busy;

  // ---------------- behavioural RAMs ----------------
  function automatic logic [31:0] ram_read(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] t);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (t)
      3'b000:  ram_read = {{24{b[7]}}, b};
      3'b100:  ram_read = {24'h0, b};
      3'b001:  ram_read = {{16{h[15]}}, h};
      3'b101:  ram_read = {16'h0, h};
      default: ram_read = w;
    endcase
  endfunction

  function automatic logic [31:0] ram_merge(input logic [31:0] w, input logic [31:0] d,
                                            input logic [1:0] a, input logic [2:0] t);
    logic [31:0] r;
    r = w;
    case (t[1:0])
      2'b00:   r[{a, 3'b000} +: 8] = d[7:0];
      2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  logic [31:0] mem1 [0:255];
  logic [31:0] mem2 [0:255];
  logic [31:0] rd1 = 0, rd2a = 0, rd2b = 0;

  always @(posedge clk) begin
    if (bus1.ram_wr_en)
      mem1[bus1.ram_addr[9:2]] <= ram_merge(mem1[bus1.ram_addr[9:2]], bus1.ram_dat_i,
                                            bus1.ram_addr[1:0], bus1.ram_rw_type);
    rd1 <= ram_read(mem1[bus1.ram_addr[9:2]], bus1.ram_addr[1:0], bus1.ram_rw_type);
  end

  always @(posedge clk) begin
    if (bus2.ram_wr_en)
      mem2[bus2.ram_addr[9:2]] <= ram_merge(mem2[bus2.ram_addr[9:2]], bus2.ram_dat_i,
                                            bus2.ram_addr[1:0], bus2.ram_rw_type);
    rd2a <= ram_read(mem2[bus2.ram_addr[9:2]], bus2.ram_addr[1:0], bus2.ram_rw_type);
    rd2b <= rd2a;
  end

  assign bus1.ram_dat_o = rd1;
  assign bus2.ram_dat_o = rd2b;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  // One access on one port; returns latency (-1 on timeout), err, rdata,
  // number of write cycles, wr_en in the first cycle, and write address/type.
  task automatic do_access(input bit port, input bit we, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output bit err, output logic [31:0] rd,
                           output int wr_cnt, output bit first_wr,
                           output logic [31:0] wr_addr, output logic [2:0] wr_type);
    @(negedge clk);
    if (port == 1'b0) begin
      p0_we = we; p0_type = t; p0_addr = a; p0_wdata = d; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_type = t; p1_addr = a; p1_wdata = d; p1_req = 1'b1;
    end
    lat = -1; err = 1'b0; rd = '0; wr_cnt = 0; first_wr = 1'b0; wr_addr = '0; wr_type = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) first_wr = wr_en;
      if (wr_en) begin
        wr_cnt++; wr_addr = ram_addr; wr_type = rw_type;
      end
      if ((port == 1'b0 && ack0) || (port == 1'b1 && ack1)) begin
        lat = i + 2;
        err = port ? err1 : err0;
        rd  = port ? rdata1 : rdata0;
        break;
      end
    end
    if (port == 1'b0) p0_req = 1'b0;
    else              p1_req = 1'b0;
  endtask

  int          lat, wc;
  bit          er, fw;
  logic [31:0] rd, wa;
  logic [2:0]  wt;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b%b want 00", ack1, ack0); end
    n_cmp++; if (err0 !== 1'b0 || err1 !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b%b want 00", err1, err0); end
    n_cmp++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h/%h want 0", rdata0, rdata1); end
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (ram_addr !== 32'h0) begin n_bad++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
    n_cmp++; if (rw_type !== 3'b010) begin n_bad++; $display("FAIL reset_rw_type: got %b want 010", rw_type); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_word_store_load();
    do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, er, rd, wc, fw, wa, wt);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sw_latency: got %0d want 3", lat); end
    n_cmp++; if (wc !== 1) begin n_bad++; $display("FAIL sw_wr_pulses: got %0d want 1", wc); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL sw_err: got %b want 0", er); end
    do_access(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, lat, er, rd, wc, fw, wa, wt);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL lw_latency: got %0d want 4", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
    n_cmp++; if (wc !== 0) begin n_bad++; $display("FAIL lw_wr_pulses: got %0d want 0", wc); end
  endtask

  task automatic test_subword_store();
    do_access(1'b1, 1'b1, 3'b000, 32'h12, 32'h55, lat, er, rd, wc, fw, wa, wt);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL sb_latency: got %0d want 4", lat); end
    n_cmp++; if (fw !== 1'b0) begin n_bad++; $display("FAIL sb_read_first: got wr_en %b want 0", fw); end
    n_cmp++; if (wc !== 1) begin n_bad++; $display("FAIL sb_wr_pulses: got %0d want 1", wc); end
    n_cmp++; if (wa[31:2] !== 30'h4) begin n_bad++; $display("FAIL sb_wr_word: got %h want word of 0x10", wa); end
    n_cmp++; if (wt !== 3'b000) begin n_bad++; $display("FAIL sb_wr_type: got %b want 000", wt); end
    do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, lat, er, rd, wc, fw, wa, wt);
    n_cmp++; if (rd !== 32'hDE55BEEF) begin n_bad++; $display("FAIL sb_merged_word: got %h want de55beef", rd); end
  endtask

  task automatic test_round_robin();
    int order[6];
    int n, c0, c1;
    int exp_order[6];
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 1, 1, 1};
`else
    exp_order = '{0, 1, 0, 1, 0, 1};
`endif
    order = '{-1, -1, -1, -1, -1, -1};
    n = 0; c0 = 0; c1 = 0;
    @(negedge clk);
    p0_we = 0; p0_type = 3'b010; p0_addr = 32'h10; p0_req = 1'b1;
    p1_we = 0; p1_type = 3'b010; p1_addr = 32'h10; p1_req = 1'b1;
    for (int i = 0; i < 80 && n < 6; i++) begin
      @(negedge clk);
      if (ack0) begin
        order[n] = 0; n++; c0++;
        if (c0 == 3) p0_req = 1'b0;
      end
      if (ack1 && n < 6) begin
        order[n] = 1; n++; c1++;
        if (c1 == 3) p1_req = 1'b0;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (order[k] !== exp_order[k]) begin
        n_bad++; $display("FAIL grant_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] prev;
    prev = rdata0;
    do_access(1'b0, 1'b0, 3'b001, 32'h13, 32'h0, lat, er, rd, wc, fw, wa, wt);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mis_latency: got %0d want 2", lat); end
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", er); end
    n_cmp++; if (wc !== 0) begin n_bad++; $display("FAIL mis_wr_pulses: got %0d want 0", wc); end
    n_cmp++; if (rd !== prev) begin n_bad++; $display("FAIL mis_rdata_held: got %h want %h", rd, prev); end
  endtask

  task automatic test_reset_in_merge();
    do_access(1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, lat, er, rd, wc, fw, wa, wt);
    @(negedge clk);
    p0_we = 1; p0_type = 3'b001; p0_addr = 32'h20; p0_wdata = 32'h0000AAAA; p0_req = 1'b1;
    @(negedge clk);  // ACCESS
    @(negedge clk);  // MERGE
    n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL merge_wr_en: got %b want 1", wr_en); end
    rst = 1'b1;
    #1;
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_gates_wr_en: got %b want 0", wr_en); end
    @(negedge clk);
    p0_req = 1'b0;
    n_cmp++; if (busy !== 1'b0 || ack0 !== 1'b0 || wr_en !== 1'b0) begin
      n_bad++; $display("FAIL rst_outputs: got busy %b ack %b wr_en %b want 000", busy, ack0, wr_en); end
    n_cmp++; if (ram_addr !== 32'h0 || rw_type !== 3'b010 || rdata0 !== 32'h0) begin
      n_bad++; $display("FAIL rst_ram_regs: got addr %h type %b rdata %h want 0/010/0", ram_addr, rw_type, rdata0); end
    rst = 1'b0;
    do_access(1'b0, 1'b0, 3'b010, 32'h20, 32'h0, lat, er, rd, wc, fw, wa, wt);
    n_cmp++; if (rd !== 32'h11223344) begin n_bad++; $display("FAIL rst_word_intact: got %h want 11223344", rd); end
  endtask

  task automatic test_rd_lat2();
    dsel = 1'b1;
    do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'h0000F300, lat, er, rd, wc, fw, wa, wt);
    do_access(1'b0, 1'b0, 3'b100, 32'h11, 32'h0, lat, er, rd, wc, fw, wa, wt);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL lat2_lbu_latency: got %0d want 5", lat); end
    n_cmp++; if (rd !== 32'h000000F3) begin n_bad++; $display("FAIL lat2_lbu_rdata: got %h want 000000f3", rd); end
    do_access(1'b0, 1'b0, 3'b000, 32'h11, 32'h0, lat, er, rd, wc, fw, wa, wt);
    n_cmp++; if (rd !== 32'hFFFFFFF3) begin n_bad++; $display("FAIL lat2_lb_rdata: got %h want fffffff3", rd); end
    do_access(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000BEEF, lat, er, rd, wc, fw, wa, wt);
    n_cmp++; if (lat !== 5 || wc !== 1) begin n_bad++; $display("FAIL lat2_sh: got lat %0d writes %0d want 5/1", lat, wc); end
    do_access(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, lat, er, rd, wc, fw, wa, wt);
    n_cmp++; if (rd !== 32'hBEEFF300) begin n_bad++; $display("FAIL lat2_sh_merge: got %h want beeff300", rd); end
    dsel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_subword_store();
    test_round_robin();
    test_misaligned();
    test_reset_in_merge();
    test_rd_lat2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single-port data RAM (sync-read BRAM, 1-cycle read latency, combinational byte/halfword merge on the RAM side) between two requesters: port 0 is the core load/store unit, port 1 is the debug/boot loader.
- Sequences each access so that sub-word stores get their read-before-write cycle.
- Rejects misaligned accesses without touching the RAM.
- Returns read data on a registered response.

Parameters:
- RD_LAT, 1, RAM read latency in cycles (legal: 1 or 2; 2 when the BRAM output register is enabled).
- ADDR_W, 32, requester/RAM address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pN_req  in  1  request, N=0,1; held with fields stable until pN_ack
- pN_we  in  1  1=store, 0=load
- pN_type  in  3  rw_type: 000 b, 001 h, 010 w, 100 bu, 101 hu
- pN_addr  in  ADDR_W  byte address
- pN_wdata  in  32  store data, right-aligned
- pN_ack  out  1  one-cycle completion pulse
- pN_err  out  1  valid with ack; misaligned access
- pN_rdata  out  32  load result, valid with ack, held until next ack on that port
- ram_wr_en  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_rw_type  out  3  RAM access type
- ram_dat_i  out  32  RAM write data
- ram_dat_o  in  32  RAM read data, already extended/selected
- busy  out  1  high in any state but IDLE

Behaviour:
- Reset values: all ack/err = 0, rdata = 0, ram_wr_en = 0, ram_addr = 0, ram_rw_type = 010, busy = 0. FSM goes to IDLE. Last-grant register = 1, so port 0 wins the first tie.
- ram_wr_en is gated low whenever rst=1. A write in flight at reset is dropped, never half-issued.
- States: IDLE, ACCESS, MERGE, CAPTURE, DONE.
- IDLE:
  - If any req, the winner latches port/we/type/addr/wdata into internal registers.
  - Misaligned (h with addr[0]=1; w with addr[1:0]!=0; type 011/110/111) -> DONE with err.
  - Otherwise -> ACCESS.
  - Winner: the sole requester, else round-robin (the port not granted last).
- ACCESS: drives ram_addr/ram_rw_type/ram_dat_i from the latched fields.
  - Word store: ram_wr_en=1 -> DONE.
  - Sub-word store: ram_wr_en=0 (old word read) -> CAPTURE with merge flag, wait RD_LAT-1 extra cycles -> MERGE.
  - Load: ram_wr_en=0 -> CAPTURE.
- CAPTURE: a counter waits RD_LAT cycles from the ACCESS edge. For a load, ram_dat_o is registered into the port's rdata on the last cycle -> DONE.
- MERGE: same address, ram_wr_en=1. The RAM merges into the old word -> DONE.
- DONE: pN_ack=1 (registered) for exactly one cycle with err/rdata -> IDLE.
  - The requester drops or changes req on the ack edge.
  - IDLE re-samples the next cycle, so back-to-back requests are served with one IDLE bubble.
- Latency, req high to ack, with RD_LAT=1: word store 3 cycles, sub-word store 4, load 4, misaligned 2.
- ram_* outputs are stable from ACCESS through MERGE. Address and type never change mid-access.
- A req dropped before its ack is protocol violation: the access completes anyway and ack is still pulsed.
- Both ports requesting continuously: grants strictly alternate 0,1,0,1.

Optional Feature:
- RAM_ARB_FIXED_PRIO_EN:
  - Defined: port 0 always wins simultaneous requests and the last-grant register is removed. Port 1 can starve.
  - Undefined: round-robin as above.

Decomposition:
- Shared package ram_arb_pkg holds:
  - FSM state encodings.
  - rw_type constants RW_LB=000, RW_LH=001, RW_LW=010, RW_LBU=100, RW_LHU=101.
  - Misalignment check function.
  - PORT0/PORT1 ids.
- One sub-module, ram_rr_pick: 2-way round-robin picker with last-grant state. Fixed-priority build bypasses it.

Test Plan:
- p0 sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> store ack at 3 cycles with one ram_wr_en pulse; load ack at 4 cycles, rdata=0xDEADBEEF.
- After the above, p1 sb addr 0x12 data 0x55, then lw 0x10 -> exactly one read cycle then one write cycle at addr 0x10; rdata=0xDE55BEEF.
- p0 and p1 both hold lw for 6 accesses -> ack order 0,1,0,1,0,1. With RAM_ARB_FIXED_PRIO_EN, all p0 first.
- p0 lh addr 0x13 -> ack with err=1 after 2 cycles; ram_wr_en never asserted; rdata unchanged.
- p0 sh 0x20 in flight, rst asserted in the MERGE cycle -> ram_wr_en stays 0 that cycle; word at 0x20 unchanged; all outputs at reset values next cycle.
- RD_LAT=2, p0 lbu addr 0x11 with word 0x0000F300 -> ack at 5 cycles, rdata=0x000000F3; lb same address -> 0xFFFFFFF3.
